// File: rtl/qdr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qdr_port_arbiter
// Purpose  : Shares the QDR-II+ SRAM read and write command ports among
//            NUM_PORTS packet-buffer clients with two independent
//            round-robin arbiters. Read data is steered back to the issuing
//            client in issue order through a tag FIFO. The memory BIST
//            takes exclusive ownership through a drain-then-grant handover.
// Ports    : clk, reset             - clock, synchronous active-high reset
//            wr_req/wr_addr/wr_data - per-port write command (valid)
//            wr_ack                 - write accepted (ready)
//            rd_req/rd_addr         - per-port read command (valid)
//            rd_ack                 - read accepted (ready)
//            rd_valid/rd_data       - one-hot read return and shared data
//            ram_wr_*/ram_rd_*      - registered PHY commands
//            ram_rd_valid/_data     - PHY read return
//            bist_req/bist_grant    - BIST ownership handshake
//            bist_wr_*/bist_rd_*    - BIST commands, used while granted
//            bist_rd_valid          - PHY return while BIST owns the memory
//            err_underflow          - sticky return-with-nothing-outstanding
// Revision : 1.0 - initial release
// ============================================================================
module qdr_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int TAG_DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_PORTS-1:0]     wr_req,
    input  logic [18*NUM_PORTS-1:0]  wr_addr,
    input  logic [144*NUM_PORTS-1:0] wr_data,
    output logic [NUM_PORTS-1:0]     wr_ack,
    input  logic [NUM_PORTS-1:0]     rd_req,
    input  logic [18*NUM_PORTS-1:0]  rd_addr,
    output logic [NUM_PORTS-1:0]     rd_ack,
    output logic [NUM_PORTS-1:0]     rd_valid,
    output logic [143:0]             rd_data,
    output logic                     ram_wr_en,
    output logic [17:0]              ram_wr_addr,
    output logic [143:0]             ram_wr_data,
    output logic                     ram_rd_en,
    output logic [17:0]              ram_rd_addr,
    input  logic                     ram_rd_valid,
    input  logic [143:0]             ram_rd_data,
    input  logic                     bist_req,
    output logic                     bist_grant,
    input  logic                     bist_wr_en,
    input  logic [17:0]              bist_wr_addr,
    input  logic [143:0]             bist_wr_data,
    input  logic                     bist_rd_en,
    input  logic [17:0]              bist_rd_addr,
    output logic                     bist_rd_valid,
    output logic                     err_underflow
);

    localparam int c_PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_TW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int c_CW = $clog2(TAG_DEPTH + 1);

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_DRAIN  = 2'd1,
        MODE_BIST   = 2'd2
    } mode_t;

    mode_t            r_mode;
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_outstanding;
    logic [c_TW-1:0]  r_tag_wr;
    logic [c_TW-1:0]  r_tag_rd;
    logic [c_PW-1:0]  r_tag_mem [TAG_DEPTH];

    logic [c_PW:0]    w_wr_pick;
    logic [c_PW:0]    w_rd_pick;
    logic [c_PW-1:0]  w_wr_idx;
    logic [c_PW-1:0]  w_rd_idx;
    logic             w_arb_en;
    logic             w_wr_issue;
    logic             w_rd_issue;
    logic             w_ret_client;
    logic             w_ret_pop;
    logic             w_drained;

    // Round-robin pick: first requester at or after ptr, wrapping modulo
    // NUM_PORTS. Scanning from the far end lets the nearest match win.
    // Result is {found, index}.
    function automatic logic [c_PW:0] f_rr_pick(input logic [NUM_PORTS-1:0] req,
                                                 input logic [c_PW-1:0]      ptr);
        logic [c_PW:0]   v_res;
        logic [c_PW:0]   v_sum;
        logic [c_PW-1:0] v_idx;
        v_res = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            v_sum = {1'b0, ptr} + (c_PW+1)'(k);
            if (v_sum >= (c_PW+1)'(NUM_PORTS)) begin
                v_sum = v_sum - (c_PW+1)'(NUM_PORTS);
            end
            v_idx = v_sum[c_PW-1:0];
            if (req[v_idx]) begin
                v_res = {1'b1, v_idx};
            end
        end
        return v_res;
    endfunction

    function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] idx);
        return (idx == c_PW'(NUM_PORTS - 1)) ? '0 : idx + c_PW'(1);
    endfunction

    assign w_wr_pick = f_rr_pick(wr_req, r_wr_ptr);
    assign w_rd_pick = f_rr_pick(rd_req, r_rd_ptr);
    assign w_wr_idx  = w_wr_pick[c_PW-1:0];
    assign w_rd_idx  = w_rd_pick[c_PW-1:0];

    // Acks are withheld the moment bist_req is seen so no new command is
    // accepted on the edge that starts the drain.
    assign w_arb_en   = (r_mode == MODE_NORMAL) && !bist_req && !reset;
    assign w_wr_issue = w_arb_en && w_wr_pick[c_PW];
    assign w_rd_issue = w_arb_en && w_rd_pick[c_PW] &&
                        (r_outstanding < c_CW'(TAG_DEPTH));

    assign wr_ack = w_wr_issue ? (NUM_PORTS'(1) << w_wr_idx) : '0;
    assign rd_ack = w_rd_issue ? (NUM_PORTS'(1) << w_rd_idx) : '0;

    // Returns belong to the clients except while the BIST owns the memory.
    assign w_ret_client = ram_rd_valid && (r_mode != MODE_BIST);
    assign w_ret_pop    = w_ret_client && (r_outstanding != '0);
    assign w_drained    = (r_outstanding == '0) && !ram_wr_en && !ram_rd_en;

    assign bist_rd_valid = ram_rd_valid && bist_grant;

    // Tag storage needs no reset: the read/write pointers define validity.
    always_ff @(posedge clk) begin
        if (w_rd_issue) begin
            r_tag_mem[r_tag_wr] <= w_rd_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode        <= MODE_NORMAL;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
            ram_wr_en     <= 1'b0;
            ram_wr_addr   <= '0;
            ram_wr_data   <= '0;
            ram_rd_en     <= 1'b0;
            ram_rd_addr   <= '0;
            rd_valid      <= '0;
            rd_data       <= '0;
            bist_grant    <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            // Command output register
            if (r_mode == MODE_BIST) begin
                ram_wr_en <= bist_wr_en;
                ram_rd_en <= bist_rd_en;
                if (bist_wr_en) begin
                    ram_wr_addr <= bist_wr_addr;
                    ram_wr_data <= bist_wr_data;
                end
                if (bist_rd_en) begin
                    ram_rd_addr <= bist_rd_addr;
                end
            end else begin
                ram_wr_en <= w_wr_issue;
                ram_rd_en <= w_rd_issue;
                if (w_wr_issue) begin
                    ram_wr_addr <= wr_addr[int'(w_wr_idx)*18 +: 18];
                    ram_wr_data <= wr_data[int'(w_wr_idx)*144 +: 144];
                end
                if (w_rd_issue) begin
                    ram_rd_addr <= rd_addr[int'(w_rd_idx)*18 +: 18];
                end
            end

            if (w_wr_issue) begin
                r_wr_ptr <= f_next(w_wr_idx);
            end
            if (w_rd_issue) begin
                r_rd_ptr <= f_next(w_rd_idx);
                r_tag_wr <= (r_tag_wr == c_TW'(TAG_DEPTH - 1)) ? '0 : r_tag_wr + c_TW'(1);
            end

            // Outstanding count; issue and return together cancel out.
            if (w_rd_issue && !w_ret_pop) begin
                r_outstanding <= r_outstanding + c_CW'(1);
            end else if (!w_rd_issue && w_ret_pop) begin
                r_outstanding <= r_outstanding - c_CW'(1);
            end

            // Client read return path
            if (w_ret_pop) begin
                rd_valid <= NUM_PORTS'(1) << r_tag_mem[r_tag_rd];
                rd_data  <= ram_rd_data;
                r_tag_rd <= (r_tag_rd == c_TW'(TAG_DEPTH - 1)) ? '0 : r_tag_rd + c_TW'(1);
            end else begin
                rd_valid <= '0;
            end
            if (w_ret_client && (r_outstanding == '0)) begin
                err_underflow <= 1'b1;
            end

            // Ownership handover
            case (r_mode)
                MODE_NORMAL: begin
                    if (bist_req) begin
                        r_mode <= MODE_DRAIN;
                    end
                end
                MODE_DRAIN: begin
                    if (!bist_req) begin
                        r_mode <= MODE_NORMAL;
                    end else if (w_drained) begin
                        r_mode     <= MODE_BIST;
                        bist_grant <= 1'b1;
                    end
                end
                MODE_BIST: begin
                    if (!bist_req) begin
                        r_mode     <= MODE_NORMAL;
                        bist_grant <= 1'b0;
                    end
                end
                default: begin
                    r_mode     <= MODE_NORMAL;
                    bist_grant <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qdr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_qdr_port_arbiter
// Purpose  : Directed self-checking bench for qdr_port_arbiter with a
//            queue-based PHY read-latency model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qdr_port_arbiter;

    localparam int NP = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [NP-1:0]  wr_req;
    logic [18*NP-1:0]  wr_addr;
    logic [144*NP-1:0] wr_data;
    logic [NP-1:0]  wr_ack;
    logic [NP-1:0]  rd_req;
    logic [18*NP-1:0]  rd_addr;
    logic [NP-1:0]  rd_ack;
    logic [NP-1:0]  rd_valid;
    logic [143:0]   rd_data;
    logic           ram_wr_en;
    logic [17:0]    ram_wr_addr;
    logic [143:0]   ram_wr_data;
    logic           ram_rd_en;
    logic [17:0]    ram_rd_addr;
    logic           ram_rd_valid = 1'b0;
    logic [143:0]   ram_rd_data  = '0;
    logic           bist_req;
    logic           bist_grant;
    logic           bist_wr_en;
    logic [17:0]    bist_wr_addr;
    logic [143:0]   bist_wr_data;
    logic           bist_rd_en;
    logic [17:0]    bist_rd_addr;
    logic           bist_rd_valid;
    logic           err_underflow;

    int n_cmp = 0;
    int n_err = 0;

    qdr_port_arbiter #(.NUM_PORTS(NP), .TAG_DEPTH(32)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_rd_valid(ram_rd_valid), .ram_rd_data(ram_rd_data),
        .bist_req(bist_req), .bist_grant(bist_grant),
        .bist_wr_en(bist_wr_en), .bist_wr_addr(bist_wr_addr), .bist_wr_data(bist_wr_data),
        .bist_rd_en(bist_rd_en), .bist_rd_addr(bist_rd_addr),
        .bist_rd_valid(bist_rd_valid), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [143:0] pat(input logic [17:0] a);
        return {8{a}};
    endfunction

    // PHY model: each read command returns pat(addr) phy_lat edges later.
    typedef struct {
        int          due;
        logic [17:0] addr;
    } ret_t;
    ret_t        phy_q[$];
    int          phy_lat = 12;
    int          phy_cyc = 0;
    logic        inject  = 1'b0;
    logic        phy_fire;
    logic [143:0] phy_data;

    always @(posedge clk) begin
        phy_cyc  = phy_cyc + 1;
        phy_fire = 1'b0;
        phy_data = '0;
        if (phy_q.size() > 0) begin
            if (phy_q[0].due <= phy_cyc) begin
                phy_fire = 1'b1;
                phy_data = pat(phy_q[0].addr);
                void'(phy_q.pop_front());
            end
        end
        if (ram_rd_en) begin
            phy_q.push_back('{phy_cyc + phy_lat, ram_rd_addr});
        end
        ram_rd_valid <= phy_fire | inject;
        ram_rd_data  <= phy_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int          n;
        logic        seen;
        int          nret;
        logic [3:0]  exp_oh;

        reset = 1'b1;
        wr_req = '1; rd_req = '1; bist_req = 1'b0;
        bist_wr_en = 1'b0; bist_wr_addr = '0; bist_wr_data = '0;
        bist_rd_en = 1'b0; bist_rd_addr = '0;
        for (int i = 0; i < NP; i++) begin
            wr_addr[i*18 +: 18]  = 18'h100 + 18'(i);
            wr_data[i*144 +: 144] = pat(18'h100 + 18'(i));
            rd_addr[i*18 +: 18]  = 18'h200 + 18'(i);
        end

        // ---- reset state ----
        tick(); tick();
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_rd_ack", rd_ack, 0);
        chk("rst_ram_wr_en", ram_wr_en, 0);
        chk("rst_ram_rd_en", ram_rd_en, 0);
        chk("rst_ram_wr_addr", ram_wr_addr, 0);
        chk("rst_ram_rd_addr", ram_rd_addr, 0);
        chk("rst_ram_wr_data", ram_wr_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_bist_grant", bist_grant, 0);
        chk("rst_err", err_underflow, 0);

        // ---- all four ports write: round-robin 0,1,2,3,0,1,2,3 ----
        reset = 1'b0;
        rd_req = '0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t1_wr_ack", wr_ack, 4'b0001 << (k % 4));
            tick();
            chk("t1_ram_wr_en", ram_wr_en, 1);
            chk("t1_ram_wr_addr", ram_wr_addr, 18'h100 + 18'(k % 4));
            chk("t1_ram_wr_data", ram_wr_data, pat(18'h100 + 18'(k % 4)));
        end
        wr_req = '0;
        tick();
        chk("t1_ram_wr_idle", ram_wr_en, 0);

        // ---- ports 1 and 3 read, 12-cycle PHY ----
        phy_lat = 12;
        rd_req = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_rd_ack", rd_ack, (k % 2 == 0) ? 4'b0010 : 4'b1000);
            tick();
            chk("t2_ram_rd_addr", ram_rd_addr, (k % 2 == 0) ? 18'h201 : 18'h203);
        end
        rd_req = '0;
        seen = 1'b0;
        for (int w = 0; w < 30; w++) begin
            if (rd_valid != 0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("t2_first_return", seen, 1);
        for (int k = 0; k < 8; k++) begin
            chk("t2_rd_valid", rd_valid, (k % 2 == 0) ? 4'b0010 : 4'b1000);
            chk("t2_rd_data", rd_data, pat((k % 2 == 0) ? 18'h201 : 18'h203));
            tick();
        end
        chk("t2_rd_valid_end", rd_valid, 0);

        // ---- throttling: latency 40, depth 32 ----
        do_reset();
        phy_lat = 40;
        rd_req = 4'b0001;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (rd_ack[0]) n++;
            else break;
            tick();
        end
        chk("t3_accepts", n, 32);
        seen = 1'b0;
        for (int w = 0; w < 60; w++) begin
            tick();
            if (rd_valid != 0) begin
                seen = 1'b1;
                break;
            end
            chk("t3_ack_held_low", rd_ack, 0);
        end
        chk("t3_first_return", seen, 1);
        chk("t3_return_port", rd_valid, 4'b0001);
        chk("t3_ack_resumes", rd_ack, 4'b0001);
        rd_req = '0;
        repeat (45) tick();
        chk("t3_err_clean", err_underflow, 0);

        // ---- BIST handover with 5 outstanding ----
        do_reset();
        phy_lat = 12;
        rd_req = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_rd_ack", rd_ack, (k % 2 == 0) ? 4'b0001 : 4'b0010);
            tick();
        end
        rd_req = 4'b1111;
        wr_req = 4'b1111;
        bist_req = 1'b1;
        #1;
        chk("t4_rd_ack_blocked", rd_ack, 0);
        chk("t4_wr_ack_blocked", wr_ack, 0);
        nret = 0;
        for (int w = 0; w < 40; w++) begin
            tick();
            chk("t4_grant_low", bist_grant, 0);
            chk("t4_ack_low", rd_ack | wr_ack, 0);
            if (rd_valid != 0) begin
                exp_oh = (nret % 2 == 0) ? 4'b0001 : 4'b0010;
                chk("t4_drain_return", rd_valid, exp_oh);
                nret++;
                if (nret == 5) break;
            end
        end
        chk("t4_nret", nret, 5);
        tick();
        chk("t4_grant_high", bist_grant, 1);
        bist_wr_en = 1'b1; bist_wr_addr = 18'h155; bist_wr_data = pat(18'h155);
        bist_rd_en = 1'b1; bist_rd_addr = 18'h3ab;
        tick();
        chk("t4_bist_wr_en", ram_wr_en, 1);
        chk("t4_bist_wr_addr", ram_wr_addr, 18'h155);
        chk("t4_bist_wr_data", ram_wr_data, pat(18'h155));
        chk("t4_bist_rd_en", ram_rd_en, 1);
        chk("t4_bist_rd_addr", ram_rd_addr, 18'h3ab);
        bist_wr_en = 1'b0;
        bist_rd_en = 1'b0;
        tick();
        chk("t4_bist_rd_en_off", ram_rd_en, 0);
        seen = 1'b0;
        for (int w = 0; w < 20; w++) begin
            tick();
            chk("t4_no_client_valid", rd_valid, 0);
            if (bist_rd_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t4_bist_rd_valid", seen, 1);
        chk("t4_err_clean", err_underflow, 0);
        chk("t4_ack_in_bist", rd_ack, 0);
        bist_req = 1'b0;
        rd_req = 4'b0011;
        wr_req = 4'b1100;
        tick();
        chk("t4_grant_drop", bist_grant, 0);
        #1;
        chk("t4_rd_ptr_kept", rd_ack, 4'b0010);
        chk("t4_wr_ptr_kept", wr_ack, 4'b0100);
        rd_req = '0;
        wr_req = '0;
        repeat (3) tick();

        // ---- spurious return ----
        do_reset();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        tick();
        chk("t5_err_set", err_underflow, 1);
        chk("t5_no_rd_valid", rd_valid, 0);
        tick(); tick();
        chk("t5_err_sticky", err_underflow, 1);
        do_reset();
        chk("t5_err_cleared", err_underflow, 0);

        // ---- reset mid-drain with 3 outstanding ----
        phy_lat = 20;
        rd_req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t6_rd_ack", rd_ack, 4'b0001);
            tick();
        end
        rd_req = '0;
        bist_req = 1'b1;
        tick(); tick();
        chk("t6_drain_no_grant", bist_grant, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bist_req = 1'b0;
        chk("t6_grant_after_rst", bist_grant, 0);
        chk("t6_err_after_rst", err_underflow, 0);
        wr_req = 4'b0001;
        #1;
        chk("t6_normal_after_rst", wr_ack, 4'b0001);
        wr_req = '0;
        for (int w = 0; w < 30; w++) begin
            tick();
            chk("t6_late_no_valid", rd_valid, 0);
        end
        chk("t6_late_underflow", err_underflow, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
